gmsk_rx: RTL

Non-coherent GMSK demodulator, the receive-side counterpart of gmsk_tx. Ingests signed I/Q samples, each with its own strobe, at SAMPLES_PER_SYMBOL samples per bit. Runs a differential-phase (cross-product) discriminator and integrates it over each symbol period. Emits one hard bit plus strobe per symbol for the burst/deframing logic downstream.

---
 rtl/gmsk_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gmsk_rx.sv
// gmsk_rx: non-coherent GMSK demodulator using a cross-product phase discriminator with
// integrate-and-dump per symbol. Macro GMSK_RX_SOFT_OUT_EN adds the soft_out port.
module gmsk_rx #(
    parameter int unsigned BITS_PER_SAMPLE    = 8,
    parameter int unsigned SAMPLES_PER_SYMBOL = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clk_en,
    input  logic signed [BITS_PER_SAMPLE-1:0] inphase_in,
    input  logic                              inphase_strobe,
    input  logic signed [BITS_PER_SAMPLE-1:0] quadrature_in,
    input  logic                              quadrature_strobe,
    input  logic                              symbol_sync,
    output logic                              output_bit,
    output logic                              output_bit_strobe,
    output logic                              sample_overrun
`ifdef GMSK_RX_SOFT_OUT_EN
    ,
    output logic signed [BITS_PER_SAMPLE-1:0] soft_out
`endif
);
    localparam int unsigned BW = BITS_PER_SAMPLE;
    localparam int unsigned PW = 2 * BW;
    localparam int unsigned DW = PW + 1;
    localparam int unsigned CW = $clog2(SAMPLES_PER_SYMBOL);
    localparam int unsigned AW = DW + CW;
    localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_SYMBOL - 1);

    function automatic logic signed [PW-1:0] smul(input logic signed [BW-1:0] a,
                                                  input logic signed [BW-1:0] b);
        logic signed [PW-1:0] ax, bx;
        ax = {{BW{a[BW-1]}}, a};
        bx = {{BW{b[BW-1]}}, b};
        return ax * bx;
    endfunction

    logic signed [BW-1:0] i_held_q, q_held_q, i0_q, q0_q, i1_q, q1_q;
    logic                 i_valid_q, q_valid_q, prev_valid_q;
    logic [CW-1:0]        cnt_q;
    logic                 p1_valid_q, p1_prod_q, p1_last_q;
    logic signed [PW-1:0] pa_q, pb_q;
    logic                 p2_valid_q, p2_last_q;
    logic signed [AW-1:0] acc_q, dec_sum_q;
    logic                 dec_fire_q, bit_q, bit_stb_q, ovr_q;

    logic signed [BW-1:0] i_cur, q_cur;
    logic                 i_any, q_any, pair_fire, overrun_d;
    logic [CW-1:0]        cnt_base;
    logic signed [PW-1:0] pa_d, pb_d;
    logic signed [DW-1:0] d;
    logic signed [AW-1:0] sum;

    always_comb begin
        i_cur     = inphase_strobe ? inphase_in : i_held_q;
        q_cur     = quadrature_strobe ? quadrature_in : q_held_q;
        i_any     = inphase_strobe | i_valid_q;
        q_any     = quadrature_strobe | q_valid_q;
        pair_fire = i_any & q_any;
        // A held sample still waiting for its partner gets replaced by a fresh strobe.
        overrun_d = (inphase_strobe & i_valid_q & ~q_valid_q)
                  | (quadrature_strobe & q_valid_q & ~i_valid_q);
        cnt_base  = symbol_sync ? '0 : cnt_q;
        pa_d      = p1_prod_q ? smul(i0_q, q1_q) : '0;
        pb_d      = p1_prod_q ? smul(q0_q, i1_q) : '0;
        d         = {pa_q[PW-1], pa_q} - {pb_q[PW-1], pb_q};
        sum       = acc_q + {{(AW-DW){d[DW-1]}}, d};
    end

`ifdef GMSK_RX_SOFT_OUT_EN
    localparam int unsigned SH = AW - BW;
    logic signed [AW-1:0] shifted;
    logic signed [BW-1:0] soft_d, soft_q;
    always_comb begin
        shifted = dec_sum_q >>> SH;
        if ((&shifted[AW-1:BW-1]) | ~(|shifted[AW-1:BW-1])) soft_d = shifted[BW-1:0];
        else if (shifted[AW-1]) soft_d = {1'b1, {(BW-1){1'b0}}};
        else soft_d = {1'b0, {(BW-1){1'b1}}};
    end
    assign soft_out = soft_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            i_held_q <= '0;  q_held_q <= '0;  i_valid_q <= 1'b0;  q_valid_q <= 1'b0;
            i0_q <= '0;  q0_q <= '0;  i1_q <= '0;  q1_q <= '0;
            prev_valid_q <= 1'b0;  cnt_q <= '0;
            p1_valid_q <= 1'b0;  p1_prod_q <= 1'b0;  p1_last_q <= 1'b0;
            pa_q <= '0;  pb_q <= '0;  p2_valid_q <= 1'b0;  p2_last_q <= 1'b0;
            acc_q <= '0;  dec_sum_q <= '0;  dec_fire_q <= 1'b0;
            bit_q <= 1'b0;  bit_stb_q <= 1'b0;  ovr_q <= 1'b0;
`ifdef GMSK_RX_SOFT_OUT_EN
            soft_q <= '0;
`endif
        end else if (clk_en) begin
            ovr_q <= overrun_d;
            if (inphase_strobe) i_held_q <= inphase_in;
            if (quadrature_strobe) q_held_q <= quadrature_in;
            i_valid_q <= i_any & ~pair_fire;
            q_valid_q <= q_any & ~pair_fire;

            p1_valid_q <= pair_fire;
            if (symbol_sync) begin
                prev_valid_q <= 1'b0;
                cnt_q        <= '0;
            end
            if (pair_fire) begin
                i0_q         <= i1_q;
                q0_q         <= q1_q;
                i1_q         <= i_cur;
                q1_q         <= q_cur;
                p1_prod_q    <= prev_valid_q & ~symbol_sync;
                p1_last_q    <= (cnt_base == LAST);
                prev_valid_q <= 1'b1;
                cnt_q        <= (cnt_base == LAST) ? '0 : cnt_base + 1'b1;
            end

            // Sync kills everything behind P1 so the aborted symbol never reaches a decision.
            p2_valid_q <= p1_valid_q & ~symbol_sync;
            p2_last_q  <= p1_last_q;
            pa_q       <= pa_d;
            pb_q       <= pb_d;

            dec_fire_q <= 1'b0;
            if (symbol_sync) begin
                acc_q <= '0;
            end else if (p2_valid_q) begin
                if (p2_last_q) begin
                    acc_q      <= '0;
                    dec_sum_q  <= sum;
                    dec_fire_q <= 1'b1;
                end else begin
                    acc_q <= sum;
                end
            end

            bit_stb_q <= dec_fire_q;
            if (dec_fire_q) begin
                bit_q <= ~dec_sum_q[AW-1] & (dec_sum_q != '0);
`ifdef GMSK_RX_SOFT_OUT_EN
                soft_q <= soft_d;
`endif
            end
        end
    end

    assign output_bit        = bit_q;
    assign output_bit_strobe = bit_stb_q & clk_en;
    assign sample_overrun    = ovr_q & clk_en;
endmodule
